// File: rtl/axi_mux_pkg.sv
// Shared constants and elaboration helpers for the N:1 registered AXI-Stream mux.
// The legal channel-count window and the select-width math live here.
package axi_mux_pkg;

    localparam int NUM_IN_MIN = 2;
    localparam int NUM_IN_MAX = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // A one-channel-wide select still needs a bit, so never return zero.
    function automatic int selWidth(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/axi_mux_out_stage.sv
// Output storage for the mux: a single register by default, or a 2-entry skid
// buffer with a registered ready when AXI_MUX_SKID_EN is defined.
module axi_mux_out_stage
    import axi_mux_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_pushData,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_outReady
);

`ifdef AXI_MUX_SKID_EN
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_skidData;
    logic              r_valid;
    logic              r_skidValid;
    logic              r_ready;
    logic              w_advance;
    logic              w_skidValidNext;

    assign w_advance = ~r_valid | i_outReady;

    // Skid entry fills only when a word arrives while the output is stalled.
    always_comb begin
        w_skidValidNext = r_skidValid;
        if (w_advance) begin
            w_skidValidNext = r_skidValid & i_push;
        end else if (i_push) begin
            w_skidValidNext = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_data      <= '0;
            r_skidData  <= '0;
            r_valid     <= 1'b0;
            r_skidValid <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            if (w_advance) begin
                if (r_skidValid) begin
                    r_valid <= 1'b1;
                    r_data  <= r_skidData;
                    if (i_push) r_skidData <= i_pushData;
                end else begin
                    r_valid <= i_push;
                    if (i_push) r_data <= i_pushData;
                end
            end else if (i_push) begin
                r_skidData <= i_pushData;
            end
            r_skidValid <= w_skidValidNext;
            r_ready     <= ~w_skidValidNext;
        end
    end

    assign o_ready = r_ready;
`else
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_live;

    // r_live keeps ready low for the first cycle after reset release.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_live  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (i_push) begin
                r_valid <= 1'b1;
                r_data  <= i_pushData;
            end else if (i_outReady) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_ready = r_live & (~r_valid | i_outReady);
`endif

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/axi_mux_nx1_reg.sv
// N:1 AXI-Stream mux with a registered output; sel/enable decode lives here and
// the storage scheme is chosen in axi_mux_out_stage by AXI_MUX_SKID_EN.
module axi_mux_nx1_reg
    import axi_mux_pkg::*;
#(
    parameter int    NUM_IN = 4,
    parameter int    DATA_W = 32,
    localparam int   SEL_W  = selWidth(NUM_IN)
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic                     enable,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready
);

    if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX) begin : g_badNumIn
        $error("axi_mux_nx1_reg: NUM_IN outside legal range");
    end

    logic              w_stageReady;
    logic              w_selValid;
    logic [DATA_W-1:0] w_selData;
    logic              w_push;

    // A select value with no matching channel leaves every ready low.
    always_comb begin
        in_ready   = '0;
        w_selValid = 1'b0;
        w_selData  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                in_ready[i] = enable & w_stageReady;
                w_selValid  = in_valid[i];
                w_selData   = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_push = w_selValid & enable & w_stageReady;

    axi_mux_out_stage #(
        .DATA_W(DATA_W)
    ) u_outStage (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .i_push    (w_push),
        .i_pushData(w_selData),
        .o_ready   (w_stageReady),
        .o_data    (out_data),
        .o_valid   (out_valid),
        .i_outReady(out_ready)
    );

endmodule

// File: tb/tb_axi_mux_nx1_reg.sv
// Scoreboard bench for axi_mux_nx1_reg: stimulus pushes expected words on each
// input handshake, a monitor pops and compares on each output transfer.
module tb_axi_mux_nx1_reg;

    localparam int NUM_IN = 4;
    localparam int DATA_W = 32;

    logic                     ACLK;
    logic                     ARESETN;
    logic                     enable;
    logic [1:0]               sel;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN-1:0]        in_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_ready;

    logic [31:0] expQ[$];
    int          popLog[$];
    int          passCnt = 0;
    int          checkCnt = 0;
    int          cycleCnt = 0;
    bit          randReady = 0;

    axi_mux_nx1_reg #(
        .NUM_IN(NUM_IN),
        .DATA_W(DATA_W)
    ) dut (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .enable   (enable),
        .sel      (sel),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        forever begin
            @(posedge ACLK);
            cycleCnt++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCnt++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passCnt++;
        end
    endtask

    task automatic reportFail(input string name);
        checkCnt++;
        $display("[TB] FAIL %s: bound expired before the DUT responded", name);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Offer one word on channel ch and wait (bounded) for its handshake.
    task automatic applyStimulus(input int ch, input logic [31:0] data);
        int waited;
        bit done;
        sel             = 2'(ch);
        enable          = 1'b1;
        in_valid        = '0;
        in_valid[ch]    = 1'b1;
        in_data[ch*32 +: 32] = data;
        waited = 0;
        done   = 0;
        while (!done) begin
            @(negedge ACLK);
            if (in_ready[ch]) begin
                expQ.push_back(data);
                done = 1;
            end
            tick();
            if (randReady) out_ready = 1'($urandom_range(0, 1));
            if (!done) begin
                waited++;
                if (waited > 200) begin
                    reportFail("hs_timeout");
                    done = 1;
                end
            end
        end
        in_valid = '0;
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 500) begin
            @(posedge ACLK);
            n++;
        end
        #1;
        if (expQ.size() != 0) reportFail(name);
    endtask

    // Monitor: every output transfer must match the oldest expected word.
    initial begin
        logic [31:0] exp;
        forever begin
            @(negedge ACLK);
            if (ARESETN && out_valid && out_ready) begin
                popLog.push_back(cycleCnt);
                if (expQ.size() == 0) begin
                    checkCnt++;
                    $display("[TB] FAIL unexpected_output: got %h, expected no output", out_data);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("out_data_order", out_data, exp);
                end
            end
        end
    end

    initial begin
        int  base;
        bit  sent;
        logic [3:0] probe;

        ARESETN   = 1'b0;
        enable    = 1'b0;
        sel       = '0;
        in_data   = '0;
        in_valid  = '0;
        out_ready = 1'b1;

        // Reset state
        #12;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_data", out_data, 32'd0);
        tick();
        ARESETN = 1'b1;
        tick();

        // Single capture on channel 2
        $display("[TB] single capture on ch2");
        sel      = 2'd2;
        enable   = 1'b1;
        in_valid = 4'b0100;
        in_data[2*32 +: 32] = 32'hA5A5_0001;
        @(negedge ACLK);
        checkOutput("ch2_in_ready", 32'(in_ready), 32'h4);
        expQ.push_back(32'hA5A5_0001);
        tick();
        in_valid = '0;
        checkOutput("ch2_out_valid", 32'(out_valid), 32'd1);
        checkOutput("ch2_out_data", out_data, 32'hA5A5_0001);
        tick();

        // Disabled mux blocks all channels
        $display("[TB] enable low");
        sel      = 2'd1;
        enable   = 1'b0;
        in_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            checkOutput("disabled_in_ready", 32'(in_ready), 32'd0);
            checkOutput("disabled_out_valid", 32'(out_valid), 32'd0);
            tick();
        end
        in_valid = '0;

        // Stall with sel change: held word then ch3 in order
        $display("[TB] stall with sel change");
        out_ready = 1'b1;
        applyStimulus(0, 32'h1111_1111);
        out_ready = 1'b0;
        sel       = 2'd3;
        enable    = 1'b1;
        in_valid  = 4'b1000;
        in_data[3*32 +: 32] = 32'h3333_3333;
        sent = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            checkOutput("stall_hold_data", out_data, 32'h1111_1111);
            checkOutput("stall_hold_valid", 32'(out_valid), 32'd1);
`ifndef AXI_MUX_SKID_EN
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
`endif
            if (!sent && in_ready[3]) begin
                expQ.push_back(32'h3333_3333);
                sent = 1;
            end
            tick();
            if (sent) in_valid = '0;
        end
        out_ready = 1'b1;
        if (!sent) applyStimulus(3, 32'h3333_3333);
        waitDrain("stall_drain");

        // Back-to-back stream on channel 1
        $display("[TB] ch1 stream");
        base = popLog.size();
        for (int k = 0; k < 16; k++) applyStimulus(1, 32'(k));
        waitDrain("stream_drain");
        checkOutput("stream_count", 32'(popLog.size() - base), 32'd16);
        if (popLog.size() - base == 16) begin
            checkOutput("stream_span", 32'(popLog[base+15] - popLog[base]), 32'd15);
        end

        // Random backpressure on channel 0
        $display("[TB] random backpressure");
        base      = popLog.size();
        randReady = 1;
        for (int k = 0; k < 100; k++) applyStimulus(0, 32'd1000 + 32'(k));
        randReady = 0;
        out_ready = 1'b1;
        waitDrain("random_drain");
        checkOutput("random_count", 32'(popLog.size() - base), 32'd100);

`ifdef AXI_MUX_SKID_EN
        sel      = 2'd0;
        enable   = 1'b1;
        in_valid = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge ACLK);
            #2;
            probe     = in_ready;
            out_ready = ~out_ready;
            #1;
            checkOutput("ready_indep", 32'(in_ready), 32'(probe));
        end
        out_ready = 1'b1;
        tick();
`endif

        // Reset while a word is stalled on the output
        $display("[TB] reset during stall");
        out_ready = 1'b0;
        applyStimulus(2, 32'hDEAD_BEEF);
        @(negedge ACLK);
        checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
        #2;
        ARESETN = 1'b0;
        #1;
        checkOutput("mid_reset_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_reset_data", out_data, 32'd0);
        expQ.delete();
        tick();
        tick();
        ARESETN   = 1'b1;
        sel       = 2'd2;
        enable    = 1'b1;
        in_valid  = '0;
        out_ready = 1'b1;
        @(negedge ACLK);
        checkOutput("post_reset_ready", 32'(in_ready), 32'd0);
        tick();
        applyStimulus(2, 32'h1234_5678);
        waitDrain("post_reset_drain");

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
